lfsr_range_gen: RTL and testbench
=================================

Name: lfsr_range_gen

Overview:
Parametrised LFSR random source with a request/response handshake. Each request returns a value uniformly distributed in [0, range_max]. Out-of-range candidates are rejected, and a bounded retry count guarantees the result arrives in a fixed maximum time. The game FSM uses it to draw the next card/number; the LFSR free-runs while idle for entropy.

Parameters:
N, 8, LFSR state width (N >= 2).
TAPS, 8'h1D, feedback mask; bit i set means state[i] feeds the XOR.
OUT_W, 4, result width; OUT_W <= N.
MAX_TRIES, 16, candidates examined per request before fallback (>= 1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  advance LFSR each cycle while IDLE/HOLD
seed_load  in  1  load seed_in into LFSR this cycle
seed_in  in  N  seed value
req_valid  in  1  draw request
req_ready  out  1  high in IDLE
range_max  in  OUT_W  inclusive upper bound, sampled on request accept
o_valid  out  1  result valid
o_ready  in  1  consumer accepts result
o_value  out  OUT_W  drawn value
o_fallback  out  1  result came from the fallback path
o_state  out  N  raw LFSR state (debug/seed display)

Behaviour:
- Reset: state=1, FSM=IDLE, o_valid=0, o_value=0, o_fallback=0, retry count=0, prev=0.
- LFSR step: shift right, MSB in = XOR-reduce(state & TAPS).
- Step priority per cycle: seed_load, then advance, then hold.
  - seed_load: state <= seed_in; a seed of 0 loads 1 instead.
  - Advance: in DRAW always; in IDLE/HOLD only when enable=1.
  - Zero guard: a computed next state of 0 loads 1.
- IDLE: req_ready=1. On req_valid && req_ready:
  - Latch lim = range_max.
  - Latch mask = smallest 2^k-1 >= lim; lim=0 gives mask=0.
  - Clear retry count; go DRAW.
- DRAW: req_ready=0. Each cycle:
  - cand = state[OUT_W-1:0] & mask; retry count increments.
  - Accept if cand <= lim. Then o_value <= cand, o_fallback <= 0, go HOLD.
  - Otherwise, if this was candidate number MAX_TRIES: o_value <= cand & (mask>>1), which is always < lim; o_fallback <= 1; go HOLD.
  - Otherwise stay in DRAW.
- HOLD: o_valid=1, o_value stable. On o_ready: prev <= o_value, go IDLE.
- Latency: request accept at cycle t gives earliest o_valid at t+2 and latest at t+1+MAX_TRIES.
- Seed load mid-DRAW is allowed: drawing continues from the new seed, and the retry count is not reset.
- req_valid outside IDLE is ignored; no queuing.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
Macro NO_REPEAT_EN.
- Defined: in DRAW, a candidate equal to prev (the last consumed result) is also rejected. This check is skipped when lim=0. The fallback path ignores the no-repeat check.
- Undefined: prev is not implemented; repeats are permitted.

Decomposition:
- Shared package lfsr_pkg holds:
  - FSM state encoding (IDLE, DRAW, HOLD).
  - Function mask_for(lim): computes the covering power-of-two mask.
  - Function lfsr_step(state, taps): returns the next state, including the zero guard.
- Sub-module lfsr_core (N, TAPS): state register, seed load, step/hold, zero guard.
- lfsr_range_gen holds the FSM, retry counter and result registers.

Test Plan:
- Reset, enable=1 for 2 cycles (N=8, TAPS=8'h1D) -> o_state 0x01 -> 0x80 -> 0x40.
- Reset, enable=0, request range_max=15 at t0 -> o_valid at t2, o_value=1, o_fallback=0; holds until o_ready, then req_ready=1.
- seed_load 0x0C, then request range_max=8 -> candidate 12 rejected, next state 0x06 accepted -> o_value=6 at t3.
- MAX_TRIES=1, seed 0x0C, range_max=8 -> fallback o_value=4, o_fallback=1 at t2.
- seed_load with seed_in=0 -> o_state=0x01. Request with range_max=0 -> o_value=0, regardless of NO_REPEAT_EN.
- NO_REPEAT_EN defined: 1000 draws with range_max=5, consuming each -> no two consecutive equal non-fallback results; all values <= 5; assert reset mid-DRAW -> o_valid=0 next edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and helper functions for the LFSR range generator
//
// Purpose : FSM state encoding, covering-mask computation and the LFSR
//           next-state function (with zero guard) used by lfsr_core and
//           lfsr_range_gen.
// Ports   : none (package)
package lfsr_pkg;

  // Helpers work on a fixed wide vector; callers zero-extend and truncate.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // Smallest 2^k-1 that is >= lim; lim = 0 yields 0.
  function automatic logic [MAX_W-1:0] mask_for(input logic [MAX_W-1:0] lim);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (m < lim) m = {m[MAX_W-2:0], 1'b1};
    end
    return m;
  endfunction

  // Right shift with XOR-reduced feedback into bit n-1. An all-zero result
  // would lock the register, so it is replaced by 1.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] taps,
                                                 input int               n);
    logic [MAX_W-1:0] nxt;
    nxt        = state >> 1;
    nxt[n-1]   = ^(state & taps);
    if (nxt == '0) nxt = MAX_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR state register with seed load, step/hold and zero guard
//
// Purpose : Holds the N-bit LFSR state. Priority: seed_load, then advance,
//           then hold. A zero seed or zero next state is replaced by 1.
// Ports   : clk, reset (async, active-high), seed_load, seed_in[N],
//           advance, state[N] (current LFSR value)
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int             N    = 8,
  parameter logic [N-1:0]   TAPS = 8'h1D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seed_load,
  input  logic [N-1:0] seed_in,
  input  logic         advance,
  output logic [N-1:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= N'(1);
    end else if (seed_load) begin
      state <= (seed_in == '0) ? N'(1) : seed_in;
    end else if (advance) begin
      state <= N'(lfsr_step(MAX_W'(state), MAX_W'(TAPS), N));
    end
  end

endmodule

// File: rtl/lfsr_range_gen.sv
// rtl/lfsr_range_gen.sv - request/response draw of a value in [0, range_max]
//
// Purpose : Rejection sampling on the LFSR low bits under a covering mask,
//           with a bounded number of candidates and a masked fallback.
//           Optional macro NO_REPEAT_EN also rejects a candidate equal to
//           the last consumed result (skipped when the limit is 0).
// Ports   : clk, reset (async, active-high), enable, seed_load, seed_in[N],
//           req_valid/req_ready, range_max[OUT_W], o_valid/o_ready,
//           o_value[OUT_W], o_fallback, o_state[N]
module lfsr_range_gen
  import lfsr_pkg::*;
#(
  parameter int           N         = 8,
  parameter logic [N-1:0] TAPS      = 8'h1D,
  parameter int           OUT_W     = 4,
  parameter int           MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [N-1:0]     seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] range_max,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_value,
  output logic             o_fallback,
  output logic [N-1:0]     o_state
);

  localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);

  fsm_t             fsm_q, fsm_d;
  logic [OUT_W-1:0] lim_q, mask_q, cand;
  logic [TRY_W-1:0] tries_q;
  logic             advance, cand_ok, last_try;

  // The LFSR always runs while drawing so each cycle offers a fresh candidate.
  assign advance = (fsm_q == DRAW) || enable;

  lfsr_core #(.N(N), .TAPS(TAPS)) u_core (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .advance   (advance),
    .state     (o_state)
  );

  assign cand     = o_state[OUT_W-1:0] & mask_q;
  assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));

`ifdef NO_REPEAT_EN
  logic [OUT_W-1:0] prev_q;
  assign cand_ok = (cand <= lim_q) && !((lim_q != '0) && (cand == prev_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if (fsm_q == HOLD && o_ready) begin
      prev_q <= o_value;
    end
  end
`else
  assign cand_ok = (cand <= lim_q);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d     = fsm_q;
    req_ready = 1'b0;
    o_valid   = 1'b0;
    case (fsm_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) fsm_d = DRAW;
      end
      DRAW: begin
        if (cand_ok || last_try) fsm_d = HOLD;
      end
      HOLD: begin
        o_valid = 1'b1;
        if (o_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim_q      <= '0;
      mask_q     <= '0;
      tries_q    <= '0;
      o_value    <= '0;
      o_fallback <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (req_valid) begin
            lim_q   <= range_max;
            mask_q  <= OUT_W'(mask_for(MAX_W'(range_max)));
            tries_q <= '0;
          end
        end
        DRAW: begin
          tries_q <= tries_q + TRY_W'(1);
          if (cand_ok) begin
            o_value    <= cand;
            o_fallback <= 1'b0;
          end else if (last_try) begin
            // mask>>1 is strictly below lim, so the fallback is always in range.
            o_value    <= cand & (mask_q >> 1);
            o_fallback <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_range_gen.sv
// tb/tb_lfsr_range_gen.sv - self-checking bench for lfsr_range_gen
module tb_lfsr_range_gen;

  localparam int N     = 8;
  localparam int OUT_W = 4;
  localparam int MT    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             seed_load = 1'b0;
  logic [N-1:0]     seed_in = '0;
  logic             req_valid = 1'b0;
  logic [OUT_W-1:0] range_max = '0;
  logic             o_ready = 1'b0;

  logic             req_ready, o_valid, o_fallback;
  logic [OUT_W-1:0] o_value;
  logic [N-1:0]     o_state;

  logic             f_req_ready, f_o_valid, f_o_fallback;
  logic [OUT_W-1:0] f_o_value;
  logic [N-1:0]     f_o_state;

  int errors = 0;
  int checks = 0;

  lfsr_range_gen #(.N(N), .TAPS(8'h1D), .OUT_W(OUT_W), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req_valid(req_valid), .req_ready(req_ready),
    .range_max(range_max), .o_valid(o_valid), .o_ready(o_ready),
    .o_value(o_value), .o_fallback(o_fallback), .o_state(o_state)
  );

  lfsr_range_gen #(.N(N), .TAPS(8'h1D), .OUT_W(OUT_W), .MAX_TRIES(1)) dut_fb (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req_valid(req_valid), .req_ready(f_req_ready),
    .range_max(range_max), .o_valid(f_o_valid), .o_ready(o_ready),
    .o_value(f_o_value), .o_fallback(f_o_fallback), .o_state(f_o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]     seed;
    logic [OUT_W-1:0] rmax;
    logic [OUT_W-1:0] val;
    logic             fb;
    int               cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until o_valid; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    tick();
    while (!o_valid && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic run_row(input vec_t v);
    int cyc;
    seed_in = v.seed;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed_state", 32'(o_state), (v.seed == '0) ? 32'd1 : 32'(v.seed));
    check("idle_ready", 32'(req_ready), 32'd1);
    range_max = v.rmax;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("draw_not_ready", 32'(req_ready), 32'd0);
    wait_valid(cyc);
    check("latency", 32'(cyc), 32'(v.cyc));
    check("value", 32'(o_value), 32'(v.val));
    check("fallback", 32'(o_fallback), 32'(v.fb));
    tick();
    check("hold_valid", 32'(o_valid), 32'd1);
    check("hold_value", 32'(o_value), 32'(v.val));
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check("back_idle", 32'(req_ready), 32'd1);
    check("valid_drop", 32'(o_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_draws;
    logic [OUT_W-1:0] last;
    logic have_last;

    vecs[0] = '{8'h01, 4'd15, 4'd1,  1'b0, 1};
    vecs[1] = '{8'h0C, 4'd8,  4'd6,  1'b0, 2};
    vecs[2] = '{8'h00, 4'd0,  4'd0,  1'b0, 1};
    vecs[3] = '{8'hFF, 4'd15, 4'd15, 1'b0, 1};
    vecs[4] = '{8'hF9, 4'd8,  4'd7,  1'b0, 9};
    vecs[5] = '{8'hFD, 4'd13, 4'd13, 1'b0, 1};

    // Reset values, then free-run two steps.
    tick();
    tick();
    reset = 1'b0;
    enable = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_value", 32'(o_value), 32'd0);
    check("rst_fallback", 32'(o_fallback), 32'd0);
    check("rst_state", 32'(o_state), 32'h01);
    tick();
    check("step1", 32'(o_state), 32'h80);
    tick();
    check("step2", 32'(o_state), 32'h40);
    enable = 1'b0;

    for (int i = 0; i < 6; i++) run_row(vecs[i]);

    // MAX_TRIES=1 instance takes the fallback on the first rejection.
    seed_in = 8'h0C;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    range_max = 4'd8;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("fb_valid", 32'(f_o_valid), 32'd1);
    check("fb_value", 32'(f_o_value), 32'd4);
    check("fb_flag", 32'(f_o_fallback), 32'd1);
    check("main_not_yet", 32'(o_valid), 32'd0);
    tick();
    check("main_valid_t3", 32'(o_valid), 32'd1);
    check("main_value_t3", 32'(o_value), 32'd6);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check("both_idle", 32'({req_ready, f_req_ready}), 32'd3);

    // Reset in the middle of a long draw.
    seed_in = 8'hF9;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    range_max = 4'd8;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_draw", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_ready", 32'(req_ready), 32'd1);
    check("async_rst_state", 32'(o_state), 32'h01);
    tick();
    check("rst_valid_edge", 32'(o_valid), 32'd0);
    reset = 1'b0;

    // Free-running draws with range_max=5.
`ifdef NO_REPEAT_EN
    n_draws = 1000;
`else
    n_draws = 100;
`endif
    enable = 1'b1;
    range_max = 4'd5;
    have_last = 1'b0;
    last = '0;
    for (int d = 0; d < n_draws; d++) begin
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_valid(cyc);
      check("rand_latency", 32'(cyc <= MT), 32'd1);
      check("rand_range", 32'(o_value <= 4'd5), 32'd1);
`ifdef NO_REPEAT_EN
      if (have_last && !o_fallback)
        check("no_repeat", 32'(o_value != last), 32'd1);
`endif
      last = o_value;
      have_last = 1'b1;
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
    end
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
